cordic_seq_ctrl: RTL

Sequencer for the floating-point cosine custom instruction. It accepts a Nios-style multi-cycle request (`start`/`dataa`) and drives the three pipeline stages in order: float→fixed convert, CORDIC cosine, fixed→float convert-back. Each stage uses a start-pulse/done handshake. The block returns a proper one-cycle `done` with the final result, replacing the tied-high `done` at the instruction top level.

---
 rtl/cordic_seq_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the floating-point cosine instruction: float->fixed, CORDIC, fixed->float.
// Defining CORDIC_CTRL_CACHE_EN adds a one-entry cache of the last normal result.

module cordic_seq_ctrl #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] NAN_WORD = 32'h7FC0_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        busy,
  output logic        timeout_err,
  output logic        cv_start,
  output logic [31:0] cv_data,
  input  logic        cv_done,
  input  logic [31:0] cv_result,
  output logic        cs_start,
  output logic [31:0] cs_theta,
  input  logic        cs_done,
  input  logic [31:0] cs_result,
  output logic        cb_start,
  output logic [31:0] cb_data,
  input  logic        cb_done,
  input  logic [31:0] cb_result
);

  localparam int unsigned   CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StConv = 2'd1;
  localparam logic [1:0] StRot  = 2'd2;
  localparam logic [1:0] StBack = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [31:0]     result_q, result_d;
  logic            busy_q, busy_d;
  logic            terr_q, terr_d;
  logic            cv_start_q, cv_start_d;
  logic [31:0]     cv_data_q, cv_data_d;
  logic            cs_start_q, cs_start_d;
  logic [31:0]     cs_theta_q, cs_theta_d;
  logic            cb_start_q, cb_start_d;
  logic [31:0]     cb_data_q, cb_data_d;

  logic            stage_done;
  logic            cache_hit;
  logic [31:0]     cache_word;
  logic            cache_wr;

  always_comb begin
    // A done in the same cycle as its own start pulse is ignored.
    stage_done = 1'b0;
    case (state_q)
      StConv:  stage_done = cv_done & ~cv_start_q;
      StRot:   stage_done = cs_done & ~cs_start_q;
      StBack:  stage_done = cb_done & ~cb_start_q;
      default: stage_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    result_d   = result_q;
    busy_d     = busy_q;
    terr_d     = terr_q;
    cv_start_d = 1'b0;
    cv_data_d  = cv_data_q;
    cs_start_d = 1'b0;
    cs_theta_d = cs_theta_q;
    cb_start_d = 1'b0;
    cb_data_d  = cb_data_q;
    cache_wr   = 1'b0;

    if (state_q == StIdle) begin
      if (start) begin
        terr_d = 1'b0;
        if (cache_hit) begin
          result_d = cache_word;
          done_d   = 1'b1;
        end else begin
          cv_data_d  = dataa;
          cv_start_d = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = StConv;
        end
      end
    end else if (stage_done) begin
      cnt_d = '0;
      case (state_q)
        StConv: begin
          cs_theta_d = cv_result;
          cs_start_d = 1'b1;
          state_d    = StRot;
        end
        StRot: begin
          cb_data_d  = cs_result;
          cb_start_d = 1'b1;
          state_d    = StBack;
        end
        default: begin
          result_d = cb_result;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cache_wr = 1'b1;
          state_d  = StIdle;
        end
      endcase
    end else if (cnt_q == CntMax) begin
      result_d = NAN_WORD;
      done_d   = 1'b1;
      terr_d   = 1'b1;
      busy_d   = 1'b0;
      cnt_d    = '0;
      state_d  = StIdle;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      cv_start_q <= 1'b0;
      cv_data_q  <= '0;
      cs_start_q <= 1'b0;
      cs_theta_q <= '0;
      cb_start_q <= 1'b0;
      cb_data_q  <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
      cv_start_q <= cv_start_d;
      cv_data_q  <= cv_data_d;
      cs_start_q <= cs_start_d;
      cs_theta_q <= cs_theta_d;
      cb_start_q <= cb_start_d;
      cb_data_q  <= cb_data_d;
    end
  end

`ifdef CORDIC_CTRL_CACHE_EN
  logic        cache_valid_q;
  logic [31:0] cache_in_q;
  logic [31:0] cache_out_q;

  // cv_data_q still holds the request word when the final stage completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
    end else if (clk_en && cache_wr) begin
      cache_valid_q <= 1'b1;
      cache_in_q    <= cv_data_q;
      cache_out_q   <= cb_result;
    end
  end

  assign cache_hit  = cache_valid_q && (dataa == cache_in_q);
  assign cache_word = cache_out_q;
`else
  logic unused_cache_wr;
  assign unused_cache_wr = cache_wr;
  assign cache_hit       = 1'b0;
  assign cache_word      = '0;
`endif

  assign done        = done_q;
  assign result      = result_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign cv_start    = cv_start_q;
  assign cv_data     = cv_data_q;
  assign cs_start    = cs_start_q;
  assign cs_theta    = cs_theta_q;
  assign cb_start    = cb_start_q;
  assign cb_data     = cb_data_q;

endmodule
